// File: rtl/up_frame_arbiter.sv
// Upstream Ethernet slot arbiter: round-robin between the local packer and a
// one-entry forward buffer, one frame in flight, completion routed back to the winner.
module up_frame_arbiter #(
  parameter int unsigned FRAME_W = 904,
  parameter logic [15:0] TIMEOUT = 16'd8192
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               loc_done,
  input  logic [FRAME_W-1:0] loc_frame,
  output logic               loc_ack,
  input  logic               fwd_valid,
  input  logic [FRAME_W-1:0] fwd_frame,
  output logic               fwd_ready,
  output logic               fwd_drop,
  input  logic               eth_ready,
  output logic               eth_valid,
  output logic [FRAME_W-1:0] eth_frame,
  input  logic               eth_ack,
  output logic               src_loc,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [FRAME_W-1:0] IDLE_PATTERN = {(FRAME_W/8){8'h55}};
  localparam logic [15:0]        TIMER_LAST   = TIMEOUT - 16'd1;

  state_t             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic               src_loc_q, src_loc_d;
  logic               last_loc_q, last_loc_d;
  logic               loc_mask_q, loc_mask_d;
  logic               fwd_full_q, fwd_full_d;
  logic               fwd_drop_q, fwd_drop_d;
  logic               timeout_err_q, timeout_err_d;
  logic [FRAME_W-1:0] fwd_buf_q, fwd_buf_d;
  logic [FRAME_W-1:0] eth_frame_q, eth_frame_d;

  logic loc_req;
  logic fwd_req;
  logic fwd_free;
  logic grant_loc;

  // The packer's done lags its ack by one cycle, so mask it right after a local release.
  assign loc_req  = loc_done & ~loc_mask_q;
  assign fwd_req  = fwd_full_q;
  assign fwd_free = (state_q == RELEASE) & ~src_loc_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    src_loc_d     = src_loc_q;
    last_loc_d    = last_loc_q;
    eth_frame_d   = eth_frame_q;
    timeout_err_d = 1'b0;
    grant_loc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (loc_req | fwd_req) begin
          grant_loc   = loc_req & (~fwd_req | ~last_loc_q);
          eth_frame_d = grant_loc ? loc_frame : fwd_buf_q;
          src_loc_d   = grant_loc;
          last_loc_d  = grant_loc;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (eth_ready) begin
          timer_d = 16'd0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        if (eth_ack) begin
          state_d = RELEASE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A strobe in the freeing RELEASE cycle refills the buffer instead of dropping.
  always_comb begin
    fwd_full_d = fwd_full_q;
    fwd_buf_d  = fwd_buf_q;
    fwd_drop_d = 1'b0;
    if (fwd_free) begin
      fwd_full_d = 1'b0;
    end
    if (fwd_valid) begin
      if (~fwd_full_q | fwd_free) begin
        fwd_buf_d  = fwd_frame;
        fwd_full_d = 1'b1;
      end else begin
        fwd_drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    loc_mask_d = (state_q == RELEASE) & src_loc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= 16'd0;
      src_loc_q     <= 1'b0;
      last_loc_q    <= 1'b0;
      loc_mask_q    <= 1'b0;
      fwd_full_q    <= 1'b0;
      fwd_drop_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      eth_frame_q   <= IDLE_PATTERN;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      src_loc_q     <= src_loc_d;
      last_loc_q    <= last_loc_d;
      loc_mask_q    <= loc_mask_d;
      fwd_full_q    <= fwd_full_d;
      fwd_drop_q    <= fwd_drop_d;
      timeout_err_q <= timeout_err_d;
      eth_frame_q   <= eth_frame_d;
    end
  end

  // Buffer contents are only meaningful while fwd_full_q is set, so no reset is needed.
  always_ff @(posedge clk) begin
    fwd_buf_q <= fwd_buf_d;
  end

  assign eth_valid   = (state_q == SEND);
  assign loc_ack     = (state_q == RELEASE) & src_loc_q;
  assign fwd_ready   = ~fwd_full_q;
  assign fwd_drop    = fwd_drop_q;
  assign timeout_err = timeout_err_q;
  assign src_loc     = src_loc_q;
  assign eth_frame   = eth_frame_q;

endmodule

// File: tb/tb_up_frame_arbiter.sv
// Self-checking bench for up_frame_arbiter: directed cycle tables, hand-written
// timeout/reset sequences, then random traffic against a timestamp-based reference model.
module tb_up_frame_arbiter;

  localparam int FW = 904;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          loc_done, fwd_valid, eth_ready, eth_ack;
  logic [FW-1:0] loc_frame, fwd_frame;
  logic          loc_ack, fwd_ready, fwd_drop, eth_valid, src_loc, timeout_err;
  logic [FW-1:0] eth_frame;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  up_frame_arbiter #(.FRAME_W(FW), .TIMEOUT(16'(TO))) dut (
    .clk(clk), .rst_n(rst_n),
    .loc_done(loc_done), .loc_frame(loc_frame), .loc_ack(loc_ack),
    .fwd_valid(fwd_valid), .fwd_frame(fwd_frame), .fwd_ready(fwd_ready), .fwd_drop(fwd_drop),
    .eth_ready(eth_ready), .eth_valid(eth_valid), .eth_frame(eth_frame), .eth_ack(eth_ack),
    .src_loc(src_loc), .timeout_err(timeout_err)
  );

  task automatic chk1(input string nm, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chkf(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got low64 %h expected low64 %h at %0t", nm, act[63:0], req[63:0], $time);
    end
  endtask

  function automatic logic [FW-1:0] byte_frame(input logic [7:0] b);
    logic [FW-1:0] f;
    f      = '0;
    f[7:0] = b;
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 8; i++) f[i*8 +: 8] = 8'($urandom);
    return f;
  endfunction

  function automatic logic [FW-1:0] pattern55();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 8; i++) f[i*8 +: 8] = 8'h55;
    return f;
  endfunction

  // Reset with all inputs idle; reset-state outputs are checked while rst_n is low.
  task automatic do_reset();
    rst_n = 1'b0;
    loc_done = 1'b0; fwd_valid = 1'b0; eth_ready = 1'b0; eth_ack = 1'b0;
    loc_frame = '0; fwd_frame = '0;
    repeat (2) @(negedge clk);
    chk1("rst_eth_valid", eth_valid, 1'b0);
    chk1("rst_src_loc", src_loc, 1'b0);
    chk1("rst_loc_ack", loc_ack, 1'b0);
    chk1("rst_fwd_ready", fwd_ready, 1'b1);
    chk1("rst_fwd_drop", fwd_drop, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    chkf("rst_eth_frame", eth_frame, pattern55());
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit       seg;
    bit       ld;  logic [7:0] lb;
    bit       fv;  logic [7:0] fb;
    bit       er;  bit ea;
    bit       ev;  bit sl; bit la; bit fr; bit fd; bit te;
    logic [7:0] eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit seg, bit ld, logic [7:0] lb, bit fv, logic [7:0] fb, bit er, bit ea,
                              bit ev, bit sl, bit la, bit fr, bit fd, bit te, logic [7:0] eb);
    vec_t v;
    v.seg = seg; v.ld = ld; v.lb = lb; v.fv = fv; v.fb = fb; v.er = er; v.ea = ea;
    v.ev = ev; v.sl = sl; v.la = la; v.fr = fr; v.fd = fd; v.te = te; v.eb = eb;
    return v;
  endfunction

  task automatic fill_table();
    //            seg ld lb     fv fb     er ea  ev sl la fr fd te eb
    // local only, then done held one cycle past loc_ack
    tbl.push_back(mk(1, 1, 8'h03, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 8'h55));
    tbl.push_back(mk(0, 1, 8'h03, 0, 8'h00, 1, 0, 1, 1, 0, 1, 0, 0, 8'h03));
    tbl.push_back(mk(0, 1, 8'h03, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h03));
    tbl.push_back(mk(0, 1, 8'h03, 0, 8'h00, 0, 1, 0, 1, 0, 1, 0, 0, 8'h03));
    tbl.push_back(mk(0, 1, 8'h03, 0, 8'h00, 0, 0, 0, 1, 1, 1, 0, 0, 8'h03));
    tbl.push_back(mk(0, 1, 8'h03, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h03));
    tbl.push_back(mk(0, 0, 8'h03, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h03));
    tbl.push_back(mk(0, 0, 8'h03, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h03));
    // contention: local, forward, local; stray eth_ack while in SEND
    tbl.push_back(mk(1, 1, 8'h13, 1, 8'h04, 0, 0, 0, 0, 0, 1, 0, 0, 8'h55));
    tbl.push_back(mk(0, 1, 8'h13, 0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 0, 8'h13));
    tbl.push_back(mk(0, 1, 8'h13, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 8'h13));
    tbl.push_back(mk(0, 1, 8'h13, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0, 8'h13));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 8'h13));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 8'h04));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 0, 1, 1, 1, 0, 1, 0, 0, 8'h23));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 1, 0, 1, 1, 0, 1, 0, 0, 8'h23));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 0, 1, 0, 1, 0, 1, 0, 0, 8'h23));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, 0, 0, 0, 1, 1, 1, 0, 0, 8'h23));
    tbl.push_back(mk(0, 0, 8'h23, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h23));
    tbl.push_back(mk(0, 0, 8'h23, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 0, 8'h23));
    // overflow, then a strobe landing in the forward RELEASE cycle
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h04, 0, 0, 0, 0, 0, 1, 0, 0, 8'h55));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h66, 0, 0, 0, 0, 0, 0, 0, 0, 8'h55));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 8'h77));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 8'h77));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h77));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 8'h77));
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].seg) do_reset();
      loc_done  = tbl[i].ld; loc_frame = byte_frame(tbl[i].lb);
      fwd_valid = tbl[i].fv; fwd_frame = byte_frame(tbl[i].fb);
      eth_ready = tbl[i].er; eth_ack   = tbl[i].ea;
      #1;
      chk1($sformatf("row%0d_eth_valid", i), eth_valid, tbl[i].ev);
      chk1($sformatf("row%0d_src_loc", i), src_loc, tbl[i].sl);
      chk1($sformatf("row%0d_loc_ack", i), loc_ack, tbl[i].la);
      chk1($sformatf("row%0d_fwd_ready", i), fwd_ready, tbl[i].fr);
      chk1($sformatf("row%0d_fwd_drop", i), fwd_drop, tbl[i].fd);
      chk1($sformatf("row%0d_timeout_err", i), timeout_err, tbl[i].te);
      chk8($sformatf("row%0d_eth_frame", i), eth_frame[7:0], tbl[i].eb);
      $display("row %0d: ev=%b src=%b ack=%b rdy=%b drop=%b to=%b frame=%h", i, eth_valid, src_loc,
               loc_ack, fwd_ready, fwd_drop, timeout_err, eth_frame[7:0]);
      @(negedge clk);
    end
  endtask

  // Counts WAIT_ACK cycles from entry until the completion shows up.
  task automatic timeout_case(input bit ack_at_end);
    int cnt;
    bit seen;
    string tag;
    tag = ack_at_end ? "ackexp" : "tmo";
    do_reset();
    loc_done = 1'b1; loc_frame = byte_frame(8'h5A); eth_ready = 1'b1;
    @(negedge clk);
    chk1({tag, "_send_ev"}, eth_valid, 1'b1);
    @(negedge clk);
    chk1({tag, "_wait_ev"}, eth_valid, 1'b0);
    eth_ready = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 4 * TO) begin
      eth_ack = ack_at_end && (cnt == TO - 1);
      @(negedge clk);
      cnt++;
      eth_ack = 1'b0;
      if (timeout_err || loc_ack) seen = 1'b1;
    end
    chk1({tag, "_done_seen"}, seen, 1'b1);
    chki({tag, "_cycles"}, cnt, TO);
    chk1({tag, "_timeout_err"}, timeout_err, !ack_at_end);
    chk1({tag, "_loc_ack"}, loc_ack, 1'b1);
    $display("%s: completion after %0d cycles, timeout_err=%b loc_ack=%b", tag, cnt, timeout_err, loc_ack);
    @(negedge clk);
    chk1({tag, "_te_width"}, timeout_err, 1'b0);
    chk1({tag, "_la_width"}, loc_ack, 1'b0);
    loc_done = 1'b0;
    @(negedge clk);
    chk1({tag, "_no_retry"}, eth_valid, 1'b0);
  endtask

  task automatic reset_case();
    do_reset();
    loc_done = 1'b1; loc_frame = byte_frame(8'h31);
    fwd_valid = 1'b1; fwd_frame = byte_frame(8'h41);
    @(negedge clk);
    fwd_valid = 1'b0;
    chk1("rs_send_ev", eth_valid, 1'b1);
    chk1("rs_buf_full", fwd_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("rs_async_ev", eth_valid, 1'b0);
    chk1("rs_async_fr", fwd_ready, 1'b1);
    chkf("rs_async_frame", eth_frame, pattern55());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rs_regrant_ev", eth_valid, 1'b1);
    chk1("rs_regrant_src", src_loc, 1'b1);
    chk8("rs_regrant_frame", eth_frame[7:0], 8'h31);
    chk1("rs_buf_lost", fwd_ready, 1'b1);
    eth_ready = 1'b1;
    @(negedge clk);
    eth_ready = 1'b0;
    chk1("rs_wait_ev", eth_valid, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("rs_wait_src", src_loc, 1'b0);
    chk1("rs_wait_la", loc_ack, 1'b0);
    chkf("rs_wait_frame", eth_frame, pattern55());
    @(negedge clk);
    chk1("rs_wait_la2", loc_ack, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rs_resume_ev", eth_valid, 1'b1);
    chk1("rs_resume_src", src_loc, 1'b1);
    eth_ready = 1'b1;
    @(negedge clk);
    eth_ready = 1'b0; eth_ack = 1'b1;
    @(negedge clk);
    eth_ack = 1'b0;
    chk1("rs_resume_la", loc_ack, 1'b1);
    @(negedge clk);
    loc_done = 1'b0;
    chk1("rs_resume_la_width", loc_ack, 1'b0);
    $display("reset mid-frame sequence done");
  endtask

  // Reference model: the slot is described by timestamps of grant, handshake and release.
  task automatic random_phase(input int ncyc);
    bit            m_active, m_sent, m_owner, m_src, m_last, m_full, m_drop, m_tmo;
    int            m_wait_start, m_rel, m_mask_at, pk_clear_at, n_frames;
    logic [FW-1:0] m_frame, m_buf;
    bit            free_now, cap, lreq, freq, gl, exp_la;
    do_reset();
    m_active = 0; m_sent = 0; m_owner = 0; m_src = 0; m_last = 0; m_full = 0; m_drop = 0; m_tmo = 0;
    m_wait_start = 0; m_rel = -1; m_mask_at = -1; pk_clear_at = -1; n_frames = 0;
    m_frame = pattern55(); m_buf = '0;
    for (int c = 0; c < ncyc; c++) begin
      exp_la = (c == m_rel) && m_owner;
      chk1("rnd_eth_valid", eth_valid, m_active && !m_sent);
      chk1("rnd_src_loc", src_loc, m_src);
      chk1("rnd_loc_ack", loc_ack, exp_la);
      chk1("rnd_fwd_ready", fwd_ready, !m_full);
      chk1("rnd_fwd_drop", fwd_drop, m_drop);
      chk1("rnd_timeout_err", timeout_err, (c == m_rel) && m_tmo);
      chkf("rnd_eth_frame", eth_frame, m_frame);
      // packer: done stays up for the lag cycle after its ack, then may re-raise
      if (exp_la) pk_clear_at = c + 2;
      if (c == pk_clear_at) loc_done = 1'b0;
      if (!loc_done && $urandom_range(3) == 0) begin
        loc_done = 1'b1;
        loc_frame = rand_frame();
      end
      fwd_valid = ($urandom_range(4) == 0);
      if (fwd_valid) fwd_frame = rand_frame();
      eth_ready = 1'($urandom_range(1));
      eth_ack   = ($urandom_range(5) == 0);
      free_now = m_active && (c == m_rel) && !m_owner;
      lreq     = loc_done && (c != m_mask_at);
      freq     = m_full;
      cap      = fwd_valid && (!m_full || free_now);
      m_drop   = fwd_valid && m_full && !free_now;
      if (!m_active) begin
        if (lreq || freq) begin
          gl = lreq && (!freq || !m_last);
          m_frame = gl ? loc_frame : m_buf;
          m_src = gl; m_last = gl; m_owner = gl;
          m_active = 1; m_sent = 0; m_rel = -1; m_tmo = 0;
          n_frames++;
        end
      end else if (!m_sent) begin
        if (eth_ready) begin
          m_sent = 1;
          m_wait_start = c + 1;
        end
      end else if (m_rel < 0) begin
        if (eth_ack) begin
          m_rel = c + 1;
        end else if (c - m_wait_start == TO - 1) begin
          m_rel = c + 1;
          m_tmo = 1;
        end
      end else if (c == m_rel) begin
        m_active = 0;
        if (m_owner) m_mask_at = c + 1;
      end
      if (free_now) m_full = 0;
      if (cap) begin
        m_buf  = fwd_frame;
        m_full = 1;
      end
      @(negedge clk);
    end
    $display("random phase: %0d cycles, %0d grants", ncyc, n_frames);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    loc_done = 1'b0; fwd_valid = 1'b0; eth_ready = 1'b0; eth_ack = 1'b0;
    loc_frame = '0; fwd_frame = '0;
    fill_table();
    run_table();
    timeout_case(1'b0);
    timeout_case(1'b1);
    reset_case();
    random_phase(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
